// File: rtl/adc_sample_scheduler_if.sv
// rtl/adc_sample_scheduler_if.sv - ADC request/sample and DAC valid/ready handshake bundle
interface adc_sample_scheduler_if #(
  parameter int ADC_WIDTH = 16
);
  logic                 adc_start;
  logic                 adc_done;
  logic [ADC_WIDTH-1:0] adc_data;
  logic                 dac_valid;
  logic                 dac_ready;
  logic [ADC_WIDTH-1:0] dac_data;

  modport master (
    output adc_start,
    input  adc_done,
    input  adc_data,
    output dac_valid,
    input  dac_ready,
    output dac_data
  );

  modport slave (
    input  adc_start,
    output adc_done,
    output adc_data,
    input  dac_valid,
    output dac_ready,
    input  dac_data
  );
endinterface

// File: rtl/adc_sample_scheduler.sv
// rtl/adc_sample_scheduler.sv - periodic ADC conversion scheduler with gain, saturation and debug FIFO
module adc_sample_scheduler #(
  parameter int ADC_WIDTH      = 16,
  parameter int GAIN_WIDTH     = 8,
  parameter int GAIN_FRAC      = 4,
  parameter int PERIOD_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [PERIOD_WIDTH-1:0]       period,
  input  logic [GAIN_WIDTH-1:0]         gain,
  adc_sample_scheduler_if.master        bus,
  input  logic                          dbg_rd_en,
  output logic [ADC_WIDTH-1:0]          dbg_rd_data,
  output logic                          dbg_empty,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_count,
  output logic [15:0]                   missed_ticks,
  output logic [15:0]                   dbg_overflows,
  output logic                          timeout_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = ADC_WIDTH + GAIN_WIDTH;

  typedef enum logic [2:0] {IDLE, START, WAIT_DONE, SCALE, HANDOFF} state_t;

  state_t                  state;
  logic [PERIOD_WIDTH-1:0] cnt;
  logic [PERIOD_WIDTH-1:0] per_lat;
  logic [PERIOD_WIDTH-1:0] per_last;
  logic                    tick;
  logic [TW-1:0]           to_cnt;
  logic [ADC_WIDTH-1:0]    raw;
  logic [PW-1:0]           product;
  logic [PW-1:0]           shifted;
  logic [ADC_WIDTH-1:0]    sat;
  logic                    adc_start_q;
  logic                    dac_valid_q;
  logic [ADC_WIDTH-1:0]    dac_data_q;

  logic [ADC_WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic                    push_req;
  logic                    push;
  logic                    pop;
  logic                    full;

  assign bus.adc_start = adc_start_q;
  assign bus.dac_valid = dac_valid_q;
  assign bus.dac_data  = dac_data_q;

  // Period is latched at each wrap (and while disabled) so mid-count writes wait for the next wrap.
  always_comb begin
    per_last = (per_lat > PERIOD_WIDTH'(1)) ? per_lat - PERIOD_WIDTH'(1) : '0;
    tick     = enable && (cnt == per_last);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      per_lat <= '0;
    end else if (!enable || tick) begin
      cnt     <= '0;
      per_lat <= period;
    end else begin
      cnt <= cnt + PERIOD_WIDTH'(1);
    end
  end

  always_comb begin
    product = {{GAIN_WIDTH{1'b0}}, raw} * {{ADC_WIDTH{1'b0}}, gain};
    shifted = product >> GAIN_FRAC;
    sat     = (|shifted[PW-1:ADC_WIDTH]) ? '1 : shifted[ADC_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      adc_start_q  <= 1'b0;
      dac_valid_q  <= 1'b0;
      dac_data_q   <= '0;
      raw          <= '0;
      to_cnt       <= '0;
      timeout_err  <= 1'b0;
      missed_ticks <= '0;
    end else begin
      adc_start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            state       <= START;
            adc_start_q <= 1'b1;
          end
        end
        START: begin
          to_cnt <= '0;
          state  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.adc_done) begin
            raw   <= bus.adc_data;
            state <= SCALE;
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 2)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        SCALE: begin
          dac_data_q  <= sat;
          dac_valid_q <= 1'b1;
          state       <= HANDOFF;
        end
        HANDOFF: begin
          if (bus.dac_ready) begin
            dac_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // The tick taken in IDLE starts a sample; any other tick is lost and counted.
      if (tick && state != IDLE && missed_ticks != 16'hFFFF)
        missed_ticks <= missed_ticks + 16'd1;
    end
  end

  always_comb begin
    full     = (count == CW'(FIFO_DEPTH));
    pop      = dbg_rd_en && (count != '0);
    push_req = (state == SCALE);
    push     = push_req && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      dbg_overflows <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (push_req && !push && dbg_overflows != 16'hFFFF)
        dbg_overflows <= dbg_overflows + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= raw;
  end

  always_comb begin
    dbg_empty   = (count == '0);
    dbg_count   = count;
    dbg_rd_data = dbg_empty ? '0 : mem[rd_ptr];
  end
endmodule

// File: tb/tb_adc_sample_scheduler.sv
// tb/tb_adc_sample_scheduler.sv - self-checking bench for adc_sample_scheduler
module tb_adc_sample_scheduler;
  localparam int TO = 256;
  localparam int FD = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] period;
  logic [7:0]  gain;
  logic        dbg_rd_en;
  logic [15:0] dbg_rd_data;
  logic        dbg_empty;
  logic [4:0]  dbg_count;
  logic [15:0] missed_ticks;
  logic [15:0] dbg_overflows;
  logic        timeout_err;

  adc_sample_scheduler_if #(.ADC_WIDTH(16)) bus();

  adc_sample_scheduler #(
    .ADC_WIDTH(16), .GAIN_WIDTH(8), .GAIN_FRAC(4), .PERIOD_WIDTH(16),
    .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period), .gain(gain),
    .bus(bus), .dbg_rd_en(dbg_rd_en), .dbg_rd_data(dbg_rd_data),
    .dbg_empty(dbg_empty), .dbg_count(dbg_count), .missed_ticks(missed_ticks),
    .dbg_overflows(dbg_overflows), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_lat = 5;
  bit pending = 0;
  int resp_cnt = 0;
  int done_cyc = -100;
  logic [15:0] last_raw = '0;
  logic [15:0] raw_src[$];
  bit ev_start = 0;
  bit pop_mode = 0;
  int pop_cyc = -1;
  logic [15:0] fifo_m[$];
  int ovf_m = 0;
  int missed_m = 0;

  function automatic logic [15:0] scale(input logic [15:0] r, input logic [7:0] g);
    longint p;
    p = (longint'(r) * longint'(g)) / 16;
    return (p > 65535) ? 16'hFFFF : 16'(p);
  endfunction

  function automatic bit is_tick(input int c, input int c0, input int p);
    int pe;
    pe = (p < 2) ? 1 : p;
    return (c >= c0) && (((c - c0) % pe) == pe - 1);
  endfunction

  // One cycle: observe outputs at the falling edge, run the ADC model and the FIFO model.
  task automatic step();
    @(negedge clk);
    cyc++;
    ev_start = bus.adc_start;
    bus.adc_done = 1'b0;
    if (pop_mode) dbg_rd_en = (cyc == pop_cyc);
    if (pending) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        pending = 0;
        last_raw = (raw_src.size() > 0) ? raw_src.pop_front() : 16'($urandom);
        bus.adc_data = last_raw;
        bus.adc_done = 1'b1;
        done_cyc = cyc;
        if (pop_mode) begin
          pop_cyc = cyc + 1;
          if (fifo_m.size() > 0) void'(fifo_m.pop_front());
        end
        if (fifo_m.size() < FD) fifo_m.push_back(last_raw);
        else ovf_m++;
      end
    end
    if (ev_start && resp_lat > 0) begin
      pending = 1;
      resp_cnt = resp_lat;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    dbg_rd_en = 1'b0;
    bus.dac_ready = 1'b1;
    bus.adc_done = 1'b0;
    pending = 0;
    step();
    step();
    reset = 1'b0;
    step();
    fifo_m.delete();
    ovf_m = 0;
    missed_m = 0;
  endtask

  task automatic run_schedule(input int p, input int l, input int n, input logic [7:0] g, input string tag);
    int starts[$];
    int c0, idle_from, t, s, idx, got, budget, extra;
    logic [15:0] exp_d;
    bit prev_valid;
    enable = 1'b0;
    period = 16'(p);
    gain = g;
    resp_lat = l;
    bus.dac_ready = 1'b1;
    step();
    step();
    enable = 1'b1;
    c0 = cyc;
    idle_from = c0;
    for (int i = 0; i < n; i++) begin
      t = idle_from;
      while (!is_tick(t, c0, p)) t++;
      s = t + 1;
      starts.push_back(s);
      if (i < n - 1)
        for (int c = s; c <= s + l + 2; c++) if (is_tick(c, c0, p)) missed_m++;
      idle_from = s + l + 3;
    end
    idx = 0;
    got = 0;
    prev_valid = 0;
    budget = starts[n-1] - c0 + l + 40;
    while (got < n && budget > 0) begin
      step();
      budget--;
      if (ev_start) begin
        checks++;
        if (idx >= n || cyc != starts[idx]) begin
          errors++;
          $display("FAIL %s start idx %0d at cycle %0d, expected %0d", tag, idx, cyc - c0,
                   (idx < n) ? starts[idx] - c0 : -1);
        end
        idx++;
        if (idx == n) enable = 1'b0;
      end
      if (bus.dac_valid && !prev_valid) begin
        exp_d = scale(last_raw, g);
        checks++;
        if (cyc != done_cyc + 2 || bus.dac_data !== exp_d) begin
          errors++;
          $display("FAIL %s dac sample raw %h gain %h: got %h after %0d cycles, expected %h after 2",
                   tag, last_raw, g, bus.dac_data, cyc - done_cyc, exp_d);
        end
        got++;
      end
      prev_valid = bus.dac_valid;
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s sample count got %0d expected %0d", tag, got, n);
    end
    extra = 0;
    repeat (p + l + 6) begin
      step();
      if (ev_start) extra++;
    end
    checks++;
    if (extra != 0 || missed_ticks !== 16'(missed_m)) begin
      errors++;
      $display("FAIL %s idle/missed: extra starts %0d missed %0d expected 0 and %0d",
               tag, extra, missed_ticks, missed_m);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.adc_start, bus.dac_valid, bus.dac_data, dbg_rd_data, dbg_empty, dbg_count,
         missed_ticks, dbg_overflows, timeout_err} !== {2'b00, 32'h0, 1'b1, 5'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state start %b valid %b data %h rd %h empty %b count %0d missed %0d ovf %0d to %b",
               bus.adc_start, bus.dac_valid, bus.dac_data, dbg_rd_data, dbg_empty, dbg_count,
               missed_ticks, dbg_overflows, timeout_err);
    end
  endtask

  task automatic test_basic();
    do_reset();
    raw_src.push_back(16'h1234);
    run_schedule(10, 5, 5, 8'h10, "basic");
  endtask

  task automatic test_gain();
    logic [15:0] r;
    do_reset();
    raw_src.push_back(16'h1000);
    run_schedule(6, 2, 1, 8'h28, "gain_2p5");
    raw_src.push_back(16'h8000);
    run_schedule(6, 2, 1, 8'h20, "gain_sat");
    for (int i = 0; i < 6; i++) begin
      r = 16'($urandom);
      raw_src.push_back(r);
      run_schedule(6, 2, 1, 8'($urandom), "gain_rand");
    end
  endtask

  task automatic test_missed();
    do_reset();
    run_schedule(4, 8, 4, 8'h10, "missed");
    for (int i = 0; i < 4; i++)
      run_schedule($urandom_range(1, 7), $urandom_range(1, 9), 3, 8'($urandom), "rand_sched");
  endtask

  task automatic test_fifo();
    do_reset();
    for (int i = 1; i <= 20; i++) raw_src.push_back(16'(i));
    run_schedule(6, 1, 20, 8'h10, "fifo_fill");
    checks++;
    if (dbg_count !== 5'd16 || dbg_overflows !== 16'(ovf_m) || ovf_m != 4) begin
      errors++;
      $display("FAIL fifo_full count %0d ovf %0d expected 16 and %0d", dbg_count, dbg_overflows, ovf_m);
    end
    pop_mode = 1;
    raw_src.push_back(16'h0015);
    run_schedule(6, 1, 1, 8'h10, "fifo_push_pop");
    pop_mode = 0;
    dbg_rd_en = 1'b0;
    checks++;
    if (dbg_count !== 5'(fifo_m.size()) || dbg_overflows !== 16'(ovf_m)) begin
      errors++;
      $display("FAIL fifo_push_pop count %0d ovf %0d expected %0d and %0d",
               dbg_count, dbg_overflows, fifo_m.size(), ovf_m);
    end
    while (fifo_m.size() > 0) begin
      checks++;
      if (dbg_empty !== 1'b0 || dbg_rd_data !== fifo_m[0]) begin
        errors++;
        $display("FAIL fifo_pop got %h empty %b expected %h", dbg_rd_data, dbg_empty, fifo_m[0]);
      end
      dbg_rd_en = 1'b1;
      step();
      void'(fifo_m.pop_front());
    end
    dbg_rd_en = 1'b0;
    step();
    checks++;
    if (dbg_empty !== 1'b1 || dbg_count !== 5'd0) begin
      errors++;
      $display("FAIL fifo_drained empty %b count %0d expected 1 and 0", dbg_empty, dbg_count);
    end
    dbg_rd_en = 1'b1;
    step();
    step();
    dbg_rd_en = 1'b0;
    step();
    checks++;
    if (dbg_empty !== 1'b1 || dbg_count !== 5'd0 || dbg_rd_data !== 16'h0) begin
      errors++;
      $display("FAIL fifo_pop_empty empty %b count %0d data %h", dbg_empty, dbg_count, dbg_rd_data);
    end
    raw_src.push_back(16'hABCD);
    run_schedule(6, 1, 1, 8'h10, "fifo_wrap");
    checks++;
    if (dbg_count !== 5'd1 || dbg_rd_data !== 16'hABCD) begin
      errors++;
      $display("FAIL fifo_wrap count %0d head %h expected 1 and abcd", dbg_count, dbg_rd_data);
    end
  endtask

  task automatic test_timeout();
    int c0, s, t, budget;
    bit seen;
    do_reset();
    period = 16'd10;
    gain = 8'h10;
    resp_lat = 0;
    step();
    step();
    enable = 1'b1;
    c0 = cyc;
    budget = 40;
    seen = 0;
    while (!seen && budget > 0) begin
      step();
      budget--;
      seen = ev_start;
    end
    s = cyc;
    checks++;
    if (!seen || s != c0 + 10) begin
      errors++;
      $display("FAIL timeout_first_start at %0d expected %0d", s - c0, 10);
    end
    budget = TO + 20;
    while (timeout_err !== 1'b1 && budget > 0) begin
      step();
      budget--;
    end
    checks++;
    if (timeout_err !== 1'b1 || cyc != s + TO) begin
      errors++;
      $display("FAIL timeout_time err %b after %0d cycles expected %0d", timeout_err, cyc - s, TO);
    end
    for (int c = s; c <= s + TO - 1; c++) if (is_tick(c, c0, 10)) missed_m++;
    t = s + TO;
    while (!is_tick(t, c0, 10)) t++;
    resp_lat = 5;
    seen = 0;
    budget = 30;
    while (!seen && budget > 0) begin
      step();
      budget--;
      seen = ev_start;
    end
    enable = 1'b0;
    checks++;
    if (!seen || cyc != t + 1) begin
      errors++;
      $display("FAIL timeout_restart at %0d expected %0d", cyc - c0, t + 1 - c0);
    end
    budget = 30;
    while (bus.dac_valid !== 1'b1 && budget > 0) begin
      step();
      budget--;
    end
    checks++;
    if (bus.dac_valid !== 1'b1 || bus.dac_data !== last_raw || cyc != done_cyc + 2) begin
      errors++;
      $display("FAIL timeout_recover valid %b data %h expected %h", bus.dac_valid, bus.dac_data, last_raw);
    end
    repeat (10) step();
    checks++;
    if (missed_ticks !== 16'(missed_m) || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_missed %0d err %b expected %0d and 1", missed_ticks, timeout_err, missed_m);
    end
  endtask

  task automatic test_handoff_reset();
    int budget;
    period = 16'd5;
    gain = 8'h28;
    resp_lat = 3;
    raw_src.push_back(16'h1000);
    bus.dac_ready = 1'b0;
    step();
    step();
    enable = 1'b1;
    budget = 40;
    while (bus.dac_valid !== 1'b1 && budget > 0) begin
      step();
      budget--;
      if (ev_start) enable = 1'b0;
    end
    checks++;
    if (bus.dac_valid !== 1'b1 || bus.dac_data !== 16'h2800) begin
      errors++;
      $display("FAIL handoff_data valid %b data %h expected 1 and 2800", bus.dac_valid, bus.dac_data);
    end
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (bus.dac_valid !== 1'b1 || bus.dac_data !== 16'h2800) begin
        errors++;
        $display("FAIL handoff_hold cycle %0d valid %b data %h", i, bus.dac_valid, bus.dac_data);
      end
    end
    reset = 1'b1;
    step();
    checks++;
    if ({bus.adc_start, bus.dac_valid, bus.dac_data, dbg_rd_data, dbg_empty, dbg_count,
         missed_ticks, dbg_overflows, timeout_err} !== {2'b00, 32'h0, 1'b1, 5'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL handoff_reset valid %b data %h empty %b count %0d missed %0d ovf %0d to %b",
               bus.dac_valid, bus.dac_data, dbg_empty, dbg_count, missed_ticks, dbg_overflows, timeout_err);
    end
    reset = 1'b0;
    bus.dac_ready = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    period = 16'd1;
    gain = 8'h10;
    dbg_rd_en = 1'b0;
    bus.adc_done = 1'b0;
    bus.adc_data = 16'h0;
    bus.dac_ready = 1'b1;
    test_reset();
    test_basic();
    test_gain();
    test_missed();
    test_fifo();
    test_timeout();
    test_handoff_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
